alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//   Execute-stage controller that drives the combinational ALU_J from the instruction side.
//   Accepts one instruction per valid/ready handshake and reads its operands from an internal register file.
//   Presents registered opcode, operands and param to the ALU.
//   Captures the ALU result and status, then writes the result back and updates the flag register.
//   Sits between instruction decode and ALU_J in the Jac1-8 datapath.
// PARAMETERS
//   DataWidth      8  operand/result width; must match ALU_J
//   NumOpCodeBits  5  opcode width; must match ALU_J
//   ParamBits      8  param width; must match ALU_J
//   NumStatusBits  3  status width: [0] overflow, [1] underflow, [2] zero
//   NumRegs        4  register file depth; select width is $clog2(NumRegs)
// PORTS
//   clk           in   1              rising-edge clock
//   reset_n       in   1              synchronous reset, active low
//   instr_valid   in   1              instruction fields valid
//   instr_ready   out  1              controller can accept an instruction
//   instr_opcode  in   NumOpCodeBits  NOP=0 ADD=1 SUB=2 AND=3 OR=4 NOT=5 XOR=6 SHL=7 SHR=8 VAL=9
//   instr_dst     in   log2(NumRegs)  destination register
//   instr_src1    in   log2(NumRegs)  register that drives ALU operand1
//   instr_src2    in   log2(NumRegs)  register that drives ALU operand2
//   instr_param   in   ParamBits      shift amount / immediate, passed to the ALU unchanged
//   alu_opcode    out  NumOpCodeBits  registered, to ALU_J.opcode
//   alu_operand1  out  DataWidth      registered, to ALU_J.operand1
//   alu_operand2  out  DataWidth      registered, to ALU_J.operand2
//   alu_param     out  ParamBits      registered, to ALU_J.param
//   alu_result    in   DataWidth      from ALU_J.result
//   alu_status    in   NumStatusBits  from ALU_J.status
//   flags         out  NumStatusBits  status of the last non-NOP, legal instruction
//   done          out  1              one-cycle pulse while in WB
//   illegal_op    out  1              sticky; set by an opcode > 9, cleared only by reset
//   rd_sel        in   log2(NumRegs)  debug read select
//   rd_data       out  DataWidth      combinational read of regs[rd_sel]
// BEHAVIOUR
//   Reset (reset_n==0 at a clk edge), all of the following are cleared:
//     - FSM goes to IDLE
//     - every register, flags, done and illegal_op go to 0
//     - alu_* outputs go to 0 (ALU sees NOP)
//     - instr_ready is 0 while reset_n==0
//   FSM states: IDLE -> EXEC -> WB -> IDLE.
//   IDLE: instr_ready=1. At edge E0 with instr_valid=1:
//     - latch alu_opcode, alu_param and dst
//     - alu_operand1 <= regs[src1], alu_operand2 <= regs[src2]
//     - go to EXEC
//   EXEC: instr_ready=0; the ALU settles combinationally. At E1:
//     - res_q <= alu_result
//     - flags <= alu_status, unless the opcode is NOP or illegal
//     - go to WB
//   WB: instr_ready=0 and done=1. At E2:
//     - regs[dst] <= res_q, unless the opcode is NOP or illegal
//     - go to IDLE
//   Latency and throughput:
//     - accept at E0 -> flags visible after E1, register visible after E2
//     - next accept no earlier than E3, so at most one instruction per 3 cycles
//   Hazards: none, because a result is written back before the next instruction reads operands.
//   NOP: runs the full FSM with done pulsed; no register write; flags unchanged.
//   Illegal opcode (>9):
//     - handled as NOP and illegal_op set
//     - alu_opcode is still driven with the raw value
//   src1, src2 and dst may alias; reads use pre-writeback values.
//   Reset in EXEC or WB aborts the instruction: no writeback, no done.
//   Any register, including index 0, is writable; the registers have no width growth and wrap exactly as the ALU result does.
// TESTING
//   1. Reset, then idle -> instr_ready=1, flags=0, done=0, rd_data=0 for all rd_sel; alu_opcode=0.
//   2. VAL r0=0xFF, VAL r1=0x02, ADD r2=r0+r1 -> regs[2]=0x01, flags=3'b001, done once per instruction.
//   3. VAL r0=0x0E, VAL r1=0x0F, SUB r3=r0-r1 -> regs[3]=0xFF, flags=3'b010; then NOP -> flags stay 3'b010.
//   4. instr_valid held high for 9 cycles with ADD r0=r0+r1, r1=1, r0 starting at 0 -> exactly 3 accepts, one every 3 cycles; r0=3.
//   5. Opcode 5'd20 -> illegal_op=1 (stays set), no register change; reset_n low during EXEC of ADD -> no writeback, no done.
//   6. r0=0xF6, SHL r1=r0 with param=0x33 -> regs[1]=0x00, flags=3'b100.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   Execute-stage controller for the combinational ALU_J. It accepts one
//   instruction per valid/ready handshake and reads both operands from a small
//   internal register file. It presents registered opcode, operands and param
//   to the ALU. It then captures the ALU result and status, and finally writes
//   the result back and updates the flag register.
//   Sequence: IDLE (accept) -> EXEC (ALU settles) -> WB (write back) -> IDLE.
//
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   instr_valid / instr_ready       instruction handshake
//   instr_opcode/dst/src1/src2/param instruction fields
//   alu_opcode/operand1/operand2/param registered drive to ALU_J
//   alu_result, alu_status          combinational return from ALU_J
//   flags                           status of the last legal, non-NOP instruction
//   done                            one-cycle pulse during write-back
//   illegal_op                      sticky flag for an opcode above VAL
//   rd_sel / rd_data                debug read port into the register file
module alu_exec_ctrl #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3,
  parameter int NumRegs       = 4,
  localparam int SelBits      = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [NumOpCodeBits-1:0] instr_opcode,
  input  logic [SelBits-1:0]       instr_dst,
  input  logic [SelBits-1:0]       instr_src1,
  input  logic [SelBits-1:0]       instr_src2,
  input  logic [ParamBits-1:0]     instr_param,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] flags,
  output logic                     done,
  output logic                     illegal_op,
  input  logic [SelBits-1:0]       rd_sel,
  output logic [DataWidth-1:0]     rd_data
);

  localparam logic [NumOpCodeBits-1:0] OP_NOP  = NumOpCodeBits'(0);
  localparam logic [NumOpCodeBits-1:0] OP_LAST = NumOpCodeBits'(9);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t                     state_r;
  logic [NumOpCodeBits-1:0]   opcode_r;
  logic [DataWidth-1:0]       operand1_r;
  logic [DataWidth-1:0]       operand2_r;
  logic [ParamBits-1:0]       param_r;
  logic [SelBits-1:0]         dst_r;
  logic [DataWidth-1:0]       res_r;
  logic                       skip_r;     // NOP or illegal: no flag update, no write-back
  logic [NumStatusBits-1:0]   flags_r;
  logic                       done_r;
  logic                       illegal_r;
  logic [DataWidth-1:0]       regs_r [NumRegs];
  logic                       is_illegal_s;

  // Opcode legality of the instruction currently offered
  always_comb begin
    is_illegal_s = 1'b0;
    if (instr_opcode > OP_LAST) begin
      is_illegal_s = 1'b1;
    end else begin
      is_illegal_s = 1'b0;
    end
  end

  // Controller FSM, ALU drive registers, result capture and register file
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      opcode_r   <= {NumOpCodeBits{1'b0}};
      operand1_r <= {DataWidth{1'b0}};
      operand2_r <= {DataWidth{1'b0}};
      param_r    <= {ParamBits{1'b0}};
      dst_r      <= {SelBits{1'b0}};
      res_r      <= {DataWidth{1'b0}};
      skip_r     <= 1'b0;
      flags_r    <= {NumStatusBits{1'b0}};
      done_r     <= 1'b0;
      illegal_r  <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_r[i] <= {DataWidth{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (instr_valid) begin
            // The raw opcode goes to the ALU even when it is illegal
            opcode_r   <= instr_opcode;
            operand1_r <= regs_r[instr_src1];
            operand2_r <= regs_r[instr_src2];
            param_r    <= instr_param;
            dst_r      <= instr_dst;
            skip_r     <= (instr_opcode == OP_NOP) || is_illegal_s;
            if (is_illegal_s) begin
              illegal_r <= 1'b1;
            end
            state_r    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_r <= alu_result;
          if (!skip_r) begin
            flags_r <= alu_status;
          end
          // done is high for exactly the WB cycle
          done_r  <= 1'b1;
          state_r <= ST_WB;
        end
        ST_WB: begin
          if (!skip_r) begin
            regs_r[dst_r] <= res_r;
          end
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready only in IDLE and forced low while reset is held
  always_comb begin
    instr_ready = 1'b0;
    if (reset_n && (state_r == ST_IDLE)) begin
      instr_ready = 1'b1;
    end else begin
      instr_ready = 1'b0;
    end
  end

  assign alu_opcode   = opcode_r;
  assign alu_operand1 = operand1_r;
  assign alu_operand2 = operand2_r;
  assign alu_param    = param_r;
  assign flags        = flags_r;
  assign done         = done_r;
  assign illegal_op   = illegal_r;
  assign rd_data      = regs_r[rd_sel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl. A behavioural stand-in for ALU_J
// closes the loop. Expected results come from a reference register/flag model
// and are queued when an instruction is accepted. They are popped and compared
// when the controller pulses done.
module tb_alu_exec_ctrl;

  logic       clk;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] instr_opcode;
  logic [1:0] instr_dst;
  logic [1:0] instr_src1;
  logic [1:0] instr_src2;
  logic [7:0] instr_param;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand1;
  logic [7:0] alu_operand2;
  logic [7:0] alu_param;
  logic [7:0] alu_result;
  logic [2:0] alu_status;
  logic [2:0] flags;
  logic       done;
  logic       illegal_op;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] dst;
    logic [7:0] reg_val;
    logic [2:0] flags;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } sb_t;
  sb_t sb[$];

  logic [7:0] mregs [4];
  logic [2:0] mflags;
  logic       mill;

  alu_exec_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_dst(instr_dst),
    .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_param(instr_param),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_param(alu_param),
    .alu_result(alu_result), .alu_status(alu_status),
    .flags(flags), .done(done), .illegal_op(illegal_op),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU_J behaviour: returns {zero, underflow, overflow, result}
  function automatic logic [10:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] p);
    logic [8:0] w;
    logic [7:0] r;
    logic       ov;
    logic       un;
    w = 9'd0; r = 8'd0; ov = 1'b0; un = 1'b0;
    case (op)
      5'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; ov = w[8]; end
      5'd2: begin r = a - b; un = (a < b); end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = ~a;
      5'd6: r = a ^ b;
      5'd7: r = (p >= 8'd8) ? 8'd0 : (a << p[2:0]);
      5'd8: r = (p >= 8'd8) ? 8'd0 : (a >> p[2:0]);
      5'd9: r = p;
      default: r = 8'd0;
    endcase
    return {(r == 8'd0), un, ov, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2, alu_param);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model step at acceptance; queues the expected outcome
  task automatic sb_push(input logic [4:0] op, input logic [1:0] dst,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] p);
    logic [10:0] rv;
    logic        skip;
    sb_t         it;
    rv   = alu_fn(op, mregs[s1], mregs[s2], p);
    skip = (op == 5'd0) || (op > 5'd9);
    if (op > 5'd9) mill = 1'b1;
    if (!skip) begin
      mflags     = rv[10:8];
      mregs[dst] = rv[7:0];
    end
    it.dst = dst; it.reg_val = mregs[dst]; it.flags = mflags;
    it.op = op; it.a = mregs[s1]; it.b = mregs[s2]; it.p = p;
    if (!skip) begin
      // operands are the pre-writeback values
      it.a = (s1 == dst) ? 8'hxx : it.a;
    end
    sb.push_back(it);
  endtask

  task automatic issue(input logic [4:0] op, input logic [1:0] dst,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] p);
    sb_t        it;
    int         n;
    logic [7:0] a_exp;
    logic [7:0] b_exp;
    a_exp = mregs[s1];
    b_exp = mregs[s2];
    instr_opcode = op; instr_dst = dst; instr_src1 = s1; instr_src2 = s2;
    instr_param = p; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    sb_push(op, dst, s1, s2, p);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("exec_opcode", 32'(alu_opcode), 32'(op));
    check("exec_operands", {16'd0, alu_operand1, alu_operand2}, {16'd0, a_exp, b_exp});
    check("exec_param", 32'(alu_param), 32'(p));
    check("exec_ready_low", 32'(instr_ready), 32'd0);
    check("exec_no_done", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 5) begin
      @(posedge clk); #1; n++;
    end
    check("wb_done", 32'(done), 32'd1);
    it = sb.pop_front();
    check("wb_flags", 32'(flags), 32'(it.flags));
    check("wb_illegal", 32'(illegal_op), 32'(mill));
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    rd_sel = it.dst; #1;
    check("wb_reg", 32'(rd_data), 32'(it.reg_val));
  endtask

  initial begin
    int     accepts;
    logic [8:0] acc_mask;
    sb_t    it;

    reset_n = 1'b0; instr_valid = 1'b0; instr_opcode = 5'd0; instr_dst = 2'd0;
    instr_src1 = 2'd0; instr_src2 = 2'd0; instr_param = 8'd0; rd_sel = 2'd0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mflags = 3'd0; mill = 1'b0;

    // 1. reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready_low", 32'(instr_ready), 32'd0);
    reset_n = 1'b1; #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      check("rst_reg", 32'(rd_data), 32'd0);
    end
    @(posedge clk); #1;

    // 2. ADD with carry-out
    issue(5'd9, 2'd0, 2'd0, 2'd0, 8'hFF);
    issue(5'd9, 2'd1, 2'd0, 2'd0, 8'h02);
    issue(5'd1, 2'd2, 2'd0, 2'd1, 8'h00);
    rd_sel = 2'd2; #1;
    check("t2_r2", 32'(rd_data), 32'h01);
    check("t2_flags", 32'(flags), 32'b001);

    // 3. SUB with borrow, then NOP keeps flags
    issue(5'd9, 2'd0, 2'd0, 2'd0, 8'h0E);
    issue(5'd9, 2'd1, 2'd0, 2'd0, 8'h0F);
    issue(5'd2, 2'd3, 2'd0, 2'd1, 8'h00);
    check("t3_flags", 32'(flags), 32'b010);
    issue(5'd0, 2'd3, 2'd0, 2'd1, 8'h00);
    check("t3_nop_flags", 32'(flags), 32'b010);
    rd_sel = 2'd3; #1;
    check("t3_r3", 32'(rd_data), 32'hFF);

    // 4. valid held for 9 cycles: one accept every 3 cycles
    issue(5'd9, 2'd0, 2'd0, 2'd0, 8'h00);
    issue(5'd9, 2'd1, 2'd0, 2'd0, 8'h01);
    instr_opcode = 5'd1; instr_dst = 2'd0; instr_src1 = 2'd0; instr_src2 = 2'd1;
    instr_param = 8'h00; instr_valid = 1'b1;
    accepts = 0; acc_mask = 9'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (done) begin
        it = sb.pop_front();
        check("t4_flags", 32'(flags), 32'(it.flags));
      end
      if (instr_ready) begin
        accepts++;
        acc_mask[c] = 1'b1;
        sb_push(5'd1, 2'd0, 2'd0, 2'd1, 8'h00);
      end
      @(posedge clk);
    end
    #1; instr_valid = 1'b0;
    check("t4_accepts", 32'(accepts), 32'd3);
    check("t4_accept_slots", 32'(acc_mask), 32'b001001001);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    rd_sel = 2'd0; #1;
    check("t4_r0", 32'(rd_data), 32'd3);

    // 5. illegal opcode is sticky and acts as NOP
    issue(5'd20, 2'd2, 2'd0, 2'd1, 8'h00);
    check("t5_illegal", 32'(illegal_op), 32'd1);
    rd_sel = 2'd2; #1;
    check("t5_r2_kept", 32'(rd_data), 32'h01);
    issue(5'd9, 2'd3, 2'd0, 2'd0, 8'h55);
    check("t5_illegal_sticky", 32'(illegal_op), 32'd1);

    // 5b. reset during EXEC aborts the ADD
    instr_opcode = 5'd1; instr_dst = 2'd2; instr_src1 = 2'd0; instr_src2 = 2'd1;
    instr_valid = 1'b1;
    check("t5_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_ready", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    check("t5_abort_done2", 32'(done), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mflags = 3'd0; mill = 1'b0;
    @(posedge clk); #1;
    check("t5_abort_done3", 32'(done), 32'd0);
    check("t5_rst_illegal", 32'(illegal_op), 32'd0);
    check("t5_rst_flags", 32'(flags), 32'd0);
    check("t5_rst_aluop", 32'(alu_opcode), 32'd0);
    rd_sel = 2'd2; #1;
    check("t5_r2_none", 32'(rd_data), 32'd0);

    // 6. SHL by a large amount yields zero
    issue(5'd9, 2'd0, 2'd0, 2'd0, 8'hF6);
    issue(5'd7, 2'd1, 2'd0, 2'd0, 8'h33);
    rd_sel = 2'd1; #1;
    check("t6_r1", 32'(rd_data), 32'h00);
    check("t6_flags", 32'(flags), 32'b100);

    // aliasing: r2 = r2 XOR r2 uses pre-writeback values
    issue(5'd9, 2'd2, 2'd0, 2'd0, 8'hA5);
    issue(5'd6, 2'd2, 2'd2, 2'd2, 8'h00);
    rd_sel = 2'd2; #1;
    check("alias_r2", 32'(rd_data), 32'h00);

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
